// File: rtl/dd_fx3_pkg.sv
// Shared definitions for the FX3 transfer controller: FSM encoding, default
// burst geometry and a counter-width helper.
package dd_fx3_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DRAIN = 2'd2,
    ST_GAP   = 2'd3
  } fx3_state_e;

  localparam int DEF_PACKET_WORDS = 8192;
  localparam int DEF_PIPE_LATENCY = 2;
  localparam int DEF_FLAG_GAP     = 3;

  // Width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/strobe_delay_line.sv
// Fixed-depth shift register that aligns the FIFO read strobes with the data
// leaving the read pipeline; synchronous reset empties every stage.
module strobe_delay_line #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign dout_o = din_i;
    end else begin : g_line
      logic [WIDTH-1:0] stage_q [DEPTH];

      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        if (gi == 0) begin : g_head
          always_ff @(posedge clk_i) begin
            if (srst_i) stage_q[gi] <= '0;
            else        stage_q[gi] <= din_i;
          end
        end else begin : g_tail
          always_ff @(posedge clk_i) begin
            if (srst_i) stage_q[gi] <= '0;
            else        stage_q[gi] <= stage_q[gi-1];
          end
        end
      end

      assign dout_o = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/fx3_transfer_controller.sv
// Moves fixed-size packets from the capture FIFO to the FX3 slave FIFO: reads a
// burst, lets the pipeline drain, then waits for the FX3 flags to settle.
module fx3_transfer_controller
  import dd_fx3_pkg::*;
#(
  parameter int PACKET_WORDS = DEF_PACKET_WORDS,
  parameter int PIPE_LATENCY = DEF_PIPE_LATENCY,
  parameter int FLAG_GAP     = DEF_FLAG_GAP
) (
  input  logic        fx3Clk,
  input  logic        reset,
  input  logic        collectData,
  input  logic        dataAvailable,
  input  logic        bufferError,
  input  logic        fx3Ready,
  output logic        readData,
  output logic        fx3Write,
  output logic        fx3LastWord,
  output logic        busy,
  output logic [15:0] packetCount,
  output logic        stallError
);

  localparam int WCW = cnt_width(PACKET_WORDS);
  localparam int TMAX = (PIPE_LATENCY > FLAG_GAP) ? PIPE_LATENCY : FLAG_GAP;
  localparam int TW  = cnt_width(TMAX);
  localparam int DRAIN_LOAD_I = (PIPE_LATENCY > 0) ? PIPE_LATENCY - 1 : 0;
  localparam int GAP_LOAD_I   = (FLAG_GAP > 0) ? FLAG_GAP - 1 : 0;

  localparam logic [WCW-1:0] LAST_WORD  = WCW'(PACKET_WORDS - 1);
  localparam logic [TW-1:0]  DRAIN_LOAD = TW'(DRAIN_LOAD_I);
  localparam logic [TW-1:0]  GAP_LOAD   = TW'(GAP_LOAD_I);

  // Zero-length DRAIN/GAP phases are skipped rather than held for one cycle.
  localparam fx3_state_e AFTER_DRAIN = (FLAG_GAP > 0) ? ST_GAP : ST_IDLE;
  localparam fx3_state_e AFTER_BURST = (PIPE_LATENCY > 0) ? ST_DRAIN : AFTER_DRAIN;

  fx3_state_e       state_q, state_d;
  logic [WCW-1:0]   word_q, word_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [15:0]      packet_cnt_q, packet_cnt_d;
  logic             stall_q, stall_d;

  logic             start_ok;
  logic             last_read;
  logic [1:0]       strobe_in;
  logic [1:0]       strobe_out;

  assign start_ok = collectData & dataAvailable & fx3Ready & ~bufferError;

  always_ff @(posedge fx3Clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_ok)             state_d = ST_BURST;
      ST_BURST: if (word_q == LAST_WORD)  state_d = AFTER_BURST;
      ST_DRAIN: if (timer_q == '0)        state_d = AFTER_DRAIN;
      ST_GAP:   if (timer_q == '0)        state_d = ST_IDLE;
      default:                            state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    readData = (state_q == ST_BURST);
    busy     = (state_q != ST_IDLE);
  end

  always_comb begin
    word_d = word_q;
    if (state_q != ST_BURST && state_d == ST_BURST) word_d = '0;
    else if (readData)                              word_d = word_q + 1'b1;
  end

  always_comb begin
    timer_d = timer_q;
    if (state_d == ST_DRAIN && state_q != ST_DRAIN)    timer_d = DRAIN_LOAD;
    else if (state_d == ST_GAP && state_q != ST_GAP)   timer_d = GAP_LOAD;
    else if (timer_q != '0)                            timer_d = timer_q - 1'b1;
  end

  always_comb begin
    packet_cnt_d = packet_cnt_q;
    if (fx3LastWord) packet_cnt_d = packet_cnt_q + 16'd1;
  end

  // Dropping collectData is the host's acknowledgement, so it wins over a new stall.
  always_comb begin
    stall_d = stall_q;
    if (!collectData)                           stall_d = 1'b0;
    else if (state_q == ST_BURST && !fx3Ready)  stall_d = 1'b1;
  end

  always_ff @(posedge fx3Clk) begin
    if (reset) begin
      word_q       <= '0;
      timer_q      <= '0;
      packet_cnt_q <= '0;
      stall_q      <= 1'b0;
    end else begin
      word_q       <= word_d;
      timer_q      <= timer_d;
      packet_cnt_q <= packet_cnt_d;
      stall_q      <= stall_d;
    end
  end

  assign last_read = readData & (word_q == LAST_WORD);
  assign strobe_in = {readData, last_read};

  strobe_delay_line #(
    .DEPTH (PIPE_LATENCY),
    .WIDTH (2)
  ) u_strobe_delay (
    .clk_i  (fx3Clk),
    .srst_i (reset),
    .din_i  (strobe_in),
    .dout_o (strobe_out)
  );

  assign fx3Write    = strobe_out[1];
  assign fx3LastWord = strobe_out[0];
  assign packetCount = packet_cnt_q;
  assign stallError  = stall_q;

endmodule

// File: tb/tb_fx3_transfer_controller.sv
// Directed bench for fx3_transfer_controller at default geometry: single packet,
// back-to-back packets, stall, stop mid-burst, start gating and reset mid-burst.
module tb_fx3_transfer_controller;

  localparam int PW = 8192;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        collectData = 1'b0;
  logic        dataAvailable = 1'b0;
  logic        bufferError = 1'b0;
  logic        fx3Ready = 1'b0;
  logic        readData;
  logic        fx3Write;
  logic        fx3LastWord;
  logic        busy;
  logic [15:0] packetCount;
  logic        stallError;

  int errors = 0;
  int checks = 0;

  // Monitor state (bench-side model of bursts and the two-stage strobe delay).
  int rd_len = 0, last_burst_len = 0, burst_count = 0, gap_len = 0, last_gap = 0;
  int wr_run = 0, last_wr_len = 0, lw_count = 0, wr_at_lw = 0, align_err = 0;

  fx3_transfer_controller dut (
    .fx3Clk        (clk),
    .reset         (reset),
    .collectData   (collectData),
    .dataAvailable (dataAvailable),
    .bufferError   (bufferError),
    .fx3Ready      (fx3Ready),
    .readData      (readData),
    .fx3Write      (fx3Write),
    .fx3LastWord   (fx3LastWord),
    .busy          (busy),
    .packetCount   (packetCount),
    .stallError    (stallError)
  );

  always #5 clk = ~clk;

  initial begin : monitor
    logic rst_s, rd_prev, wr_prev, cur_lw, exp_wr, exp_lw;
    logic [1:0] hist_rd, hist_lw;
    rd_prev = 1'b0; wr_prev = 1'b0; hist_rd = '0; hist_lw = '0;
    forever begin
      @(posedge clk);
      rst_s = reset;
      @(negedge clk);
      if (rst_s) begin
        hist_rd = '0;
        hist_lw = '0;
      end
      exp_wr = hist_rd[1];
      exp_lw = hist_lw[1];
      if (fx3Write !== exp_wr || fx3LastWord !== exp_lw) align_err++;
      if (readData) begin
        if (!rd_prev) begin
          last_gap = gap_len;
          rd_len = 0;
        end
        rd_len++;
        gap_len = 0;
      end else begin
        if (rd_prev) begin
          last_burst_len = rd_len;
          burst_count++;
        end
        gap_len++;
      end
      cur_lw = readData && (rd_len == PW);
      hist_rd = {hist_rd[0], readData};
      hist_lw = {hist_lw[0], cur_lw};
      if (fx3Write) begin
        wr_run++;
        if (fx3LastWord) begin
          lw_count++;
          wr_at_lw = wr_run;
        end
      end else begin
        if (wr_prev) last_wr_len = wr_run;
        wr_run = 0;
      end
      rd_prev = readData;
      wr_prev = fx3Write;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic wait_rd_low(input string tag);
    int n = 0;
    while (readData !== 1'b0 && n < PW + 100) begin
      step();
      n++;
    end
    check(tag, {31'd0, readData}, 32'd0);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 50) begin
      step();
      n++;
    end
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_word(input int target, input string tag);
    int n = 0;
    while (rd_len != target && n < PW + 100) begin
      step();
      n++;
    end
    check(tag, rd_len, target);
  endtask

  initial begin : stimulus
    int base;

    // Reset state
    steps(3);
    check("rst_readData", {31'd0, readData}, 0);
    check("rst_fx3Write", {31'd0, fx3Write}, 0);
    check("rst_lastWord", {31'd0, fx3LastWord}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_packetCount", {16'd0, packetCount}, 0);
    check("rst_stallError", {31'd0, stallError}, 0);

    // Single packet
    reset = 1'b0; collectData = 1'b1; dataAvailable = 1'b1; fx3Ready = 1'b1;
    step();
    check("t1_start", {31'd0, readData}, 1);
    check("t1_busy", {31'd0, busy}, 1);
    dataAvailable = 1'b0;
    wait_rd_low("t1_end_timeout");
    wait_idle("t1_idle_timeout");
    check("t1_read_len", last_burst_len, PW);
    check("t1_write_len", last_wr_len, PW);
    check("t1_lastword_count", lw_count, 1);
    check("t1_lastword_pos", wr_at_lw, PW);
    check("t1_packetCount", {16'd0, packetCount}, 1);
    steps(10);
    check("t1_no_rerun", burst_count, 1);

    // Back-to-back: three packets with every input held high
    dataAvailable = 1'b1;
    base = burst_count;
    begin
      int n = 0;
      while (burst_count < base + 3 && n < 3 * PW + 200) begin
        step();
        n++;
      end
    end
    dataAvailable = 1'b0;
    check("t2_burst_count", burst_count, base + 3);
    wait_idle("t2_idle_timeout");
    check("t2_gap", last_gap, 6);
    check("t2_read_len", last_burst_len, PW);
    check("t2_packetCount", {16'd0, packetCount}, 4);

    // fx3Ready gating in IDLE, then a one-cycle stall at word 4000
    fx3Ready = 1'b0; dataAvailable = 1'b1;
    steps(5);
    check("t3_gate_ready", {31'd0, readData}, 0);
    fx3Ready = 1'b1;
    step();
    check("t3_start", {31'd0, readData}, 1);
    dataAvailable = 1'b0;
    wait_word(4000, "t3_word4000");
    fx3Ready = 1'b0;
    step();
    fx3Ready = 1'b1;
    check("t3_stall_set", {31'd0, stallError}, 1);
    wait_rd_low("t3_end_timeout");
    check("t3_read_len", last_burst_len, PW);
    wait_idle("t3_idle_timeout");
    check("t3_packetCount", {16'd0, packetCount}, 5);
    check("t3_stall_sticky", {31'd0, stallError}, 1);

    // bufferError gating, then collectData drops at word 100
    bufferError = 1'b1; dataAvailable = 1'b1;
    steps(5);
    check("t4_gate_buferr", {31'd0, readData}, 0);
    check("t4_gate_busy", {31'd0, busy}, 0);
    check("t4_stall_held", {31'd0, stallError}, 1);
    bufferError = 1'b0;
    step();
    check("t4_start", {31'd0, readData}, 1);
    base = burst_count;
    wait_word(100, "t4_word100");
    collectData = 1'b0; bufferError = 1'b1;
    step();
    check("t4_stall_clear", {31'd0, stallError}, 0);
    check("t4_still_reading", {31'd0, readData}, 1);
    wait_rd_low("t4_end_timeout");
    check("t4_read_len", last_burst_len, PW);
    wait_idle("t4_idle_timeout");
    check("t4_packetCount", {16'd0, packetCount}, 6);
    steps(20);
    check("t4_no_second", burst_count, base + 1);
    check("t4_idle_busy", {31'd0, busy}, 0);

    // Reset at word 5000, then a fresh full burst
    bufferError = 1'b0; collectData = 1'b1; dataAvailable = 1'b1;
    step();
    check("t5_start", {31'd0, readData}, 1);
    dataAvailable = 1'b0;
    wait_word(5000, "t5_word5000");
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t5_rst_readData", {31'd0, readData}, 0);
    check("t5_rst_fx3Write", {31'd0, fx3Write}, 0);
    check("t5_rst_lastWord", {31'd0, fx3LastWord}, 0);
    check("t5_rst_busy", {31'd0, busy}, 0);
    check("t5_rst_packetCount", {16'd0, packetCount}, 0);
    steps(3);
    check("t5_no_late_write", {31'd0, fx3Write}, 0);
    check("t5_lw_unchanged", lw_count, 6);
    dataAvailable = 1'b1;
    step();
    check("t5_restart", {31'd0, readData}, 1);
    dataAvailable = 1'b0;
    wait_rd_low("t5_end_timeout");
    check("t5_read_len", last_burst_len, PW);
    wait_idle("t5_idle_timeout");
    check("t5_packetCount", {16'd0, packetCount}, 1);
    check("t5_lw_total", lw_count, 7);
    check("strobe_alignment", align_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
